mem_block_bus_initiator: RTL
============================

Name: mem_block_bus_initiator

Overview:
Initiator end of the 16-bit bidirectional memory-block bus. Accepts WIDTH-bit read/write commands over a valid/ready interface and serializes each onto the shared bus as a header beat plus WIDTH/16 data beats. For reads it turns the bus around and collects the beats driven by the memory block. Returns one response per command over a valid/ready interface. Sits between the system command fabric and the memory block responder.

Parameters:
WIDTH, 32, data word width; multiple of 16, >= 16; N = WIDTH/16 beats per word
DEPTH, 1024, addressable words; AW = $clog2(DEPTH), AW <= 15
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with macro)

Ports:
clock_signal  input  1  clock; all logic on rising edge
reset_signal_active_high  input  1  asynchronous, active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1 = write, 0 = read
cmd_address  input  AW  word address
input_data_bus  input  WIDTH  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
output_data_bus  output  WIDTH  read data; 0 for writes
rsp_error  output  1  response ended by timeout
bidirectional_bus  inout  16  shared bus; high-Z when not driving
bus_strobe  output  1  high on every cycle the initiator drives a valid beat
bus_ack  input  1  responder: write-complete pulse, or read-beat valid
status_busy  output  1  high in every state except IDLE
status_timeout_count  output  8  saturating timeout counter

Behaviour:
- Reset (async): state IDLE; bus high-Z; bus_strobe, rsp_valid, rsp_error, status_busy = 0; output_data_bus = 0; status_timeout_count = 0. cmd_ready = 0 while reset is asserted. An in-flight transaction is aborted and produces no response.
- cmd_ready = (state == IDLE) outside reset.
- States and transitions:
  - IDLE: on cmd_valid & cmd_ready, latch write, address and data -> HEADER.
  - HEADER: one cycle. Drive {cmd_write, address zero-extended to 15 bits}; strobe = 1. Write -> WDATA; read -> TURN.
  - WDATA: N cycles, strobe = 1. Beat k = wdata[16k+15:16k], LS beat first. After beat N-1 -> WAIT_ACK.
  - WAIT_ACK: bus high-Z, strobe = 0. On bus_ack = 1 -> RESP with error = 0.
  - TURN: one cycle. Bus high-Z, strobe = 0; bus_ack ignored -> RDATA.
  - RDATA: bus high-Z. Each cycle with bus_ack = 1 captures the bus into beat k (k increments from 0). After beat N-1 is captured -> RESP.
  - RESP: rsp_valid = 1; output_data_bus and rsp_error held stable until rsp_ready = 1, then -> IDLE (rsp_valid low the next cycle).
- bus_ack is sampled only in WAIT_ACK and RDATA; it is ignored in all other states.
- Latency with acceptance at cycle 0, zero-stall responder: rsp_valid at cycle N+3 for both reads and writes.
- Back-to-back: the next command can be accepted no earlier than the cycle after the rsp handshake.
- Read data: the beat-assembly register is cleared on acceptance of each command.

Optional Feature:
MEM_BLOCK_INITIATOR_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_ACK and RDATA and clears on entry and on every accepted bus_ack.
  - When the counter reaches TIMEOUT_CYCLES, the state moves to RESP with rsp_error = 1.
  - Read data already captured is kept; uncaptured beats are 0.
  - status_timeout_count increments and saturates at 255.
- Undefined:
  - No watchdog; the block waits indefinitely for bus_ack.
  - rsp_error and status_timeout_count are constant 0.

Test Plan:
- WIDTH=32; write addr 0x005, data 0xDEADBEEF, bus_ack at cycle 4 -> bus shows 0x8005, 0xBEEF, 0xDEAD on cycles 1-3 with strobe = 1; rsp_valid at cycle 5; rsp_error = 0; output_data_bus = 0.
- Read addr 0x3FF, responder drives 0x1234 then 0x5678 with bus_ack on cycles 3-4 -> header 0x03FF; bus released from cycle 2; output_data_bus = 0x56781234; rsp_valid at cycle 5.
- Read with a 2-cycle ack gap between beats, and rsp_ready low for 3 cycles -> data assembles correctly; rsp_valid and data stable; cmd_ready = 0; a second cmd_valid is not accepted until the handshake.
- Macro defined, TIMEOUT_CYCLES = 8; write with no bus_ack -> rsp_error = 1 after 8 cycles in WAIT_ACK; status_timeout_count = 1. Read timing out after beat 0 = 0xAAAA -> output_data_bus = 0x0000AAAA.
- bus_ack pulsed during HEADER, WDATA and TURN -> ignored; the write still waits for an ack in WAIT_ACK.
- Reset asserted during RDATA after the first beat -> bus high-Z and strobe = 0 immediately; no rsp_valid; a following write completes normally.

Source files
------------

// File: rtl/mem_block_bus_initiator.sv
// mem_block_bus_initiator
// Initiator end of the 16-bit bidirectional memory-block bus.
// - Takes WIDTH-bit read/write commands on a valid/ready port.
// - Serialises each command as a header beat plus WIDTH/16 data beats.
// - For reads, turns the bus around and collects the beats driven by the responder.
// - Returns exactly one response per command on a valid/ready port.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge where
// valid and ready are both high. The sender holds valid and its payload stable
// until that edge. cmd_ready never depends combinationally on cmd_valid.
//
// Optional watchdog: define MEM_BLOCK_INITIATOR_TIMEOUT_EN to end a stalled
// WAIT_ACK/RDATA phase after TIMEOUT_CYCLES cycles with rsp_error = 1.
// Without the macro the block waits indefinitely for the responder, and
// rsp_error / status_timeout_count are tied to 0.
module mem_block_bus_initiator #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 1024,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             clock_signal,
  input  logic             reset_signal_active_high,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_address,
  input  logic [WIDTH-1:0] input_data_bus,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] output_data_bus,
  output logic             rsp_error,
  inout  wire  [15:0]      bidirectional_bus,
  output logic             bus_strobe,
  input  logic             bus_ack,
  output logic             status_busy,
  output logic [7:0]       status_timeout_count,
  output logic [2:0]       dbg_state
);

  localparam int N  = WIDTH / 16;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

  // Parameter sanity, caught at elaboration.
  if ((WIDTH % 16) != 0 || WIDTH < 16 || AW > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_block_bus_initiator: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADER   = 3'd1,
    WDATA    = 3'd2,
    WAIT_ACK = 3'd3,
    TURN     = 3'd4,
    RDATA    = 3'd5,
    RESP     = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic                   write_q;
  logic [AW-1:0]          addr_q;
  logic [N-1:0][15:0]     wdata_q;
  logic [N-1:0][15:0]     rdata_q;
  logic [BW-1:0]          beat_idx;
  logic                   bus_oe;
  logic [15:0]            bus_out;
  logic                   timeout_hit;
  logic [14:0]            addr_ext;

  assign addr_ext = 15'(addr_q);

  // Tristate driver: only HEADER and WDATA put a value on the shared bus.
  assign bidirectional_bus = bus_oe ? bus_out : 16'hzzzz;

  assign cmd_ready       = (state_q == IDLE) && !reset_signal_active_high;
  assign rsp_valid       = (state_q == RESP);
  assign status_busy     = (state_q != IDLE);
  assign bus_strobe      = bus_oe;
  assign output_data_bus = rdata_q;
  assign dbg_state       = state_q;

  // Next-state and bus-drive decode.
  always_comb begin
    state_d = state_q;
    bus_oe  = 1'b0;
    bus_out = 16'h0000;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = HEADER;
      end
      HEADER: begin
        bus_oe  = 1'b1;
        bus_out = {write_q, addr_ext};
        state_d = write_q ? WDATA : TURN;
      end
      WDATA: begin
        bus_oe  = 1'b1;
        bus_out = wdata_q[beat_idx];
        if (beat_idx == LAST_BEAT) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus_ack)          state_d = RESP;
        else if (timeout_hit) state_d = RESP;
      end
      TURN: begin
        // Dead cycle so the responder can start driving without contention.
        state_d = RDATA;
      end
      RDATA: begin
        if (bus_ack) begin
          if (beat_idx == LAST_BEAT) state_d = RESP;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, command latch, beat counter and read-data assembly.
  always_ff @(posedge clock_signal or posedge reset_signal_active_high) begin
    if (reset_signal_active_high) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      beat_idx <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            write_q  <= cmd_write;
            addr_q   <= cmd_address;
            wdata_q  <= input_data_bus;
            rdata_q  <= '0;
            beat_idx <= '0;
          end
        end
        WDATA: begin
          beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + 1'b1;
        end
        RDATA: begin
          if (bus_ack) begin
            rdata_q[beat_idx] <= bidirectional_bus;
            beat_idx          <= beat_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_BLOCK_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          err_q;
  logic [7:0]    to_count_q;
  logic          waiting;
  logic          timeout_fire;

  assign waiting      = (state_q == WAIT_ACK) || (state_q == RDATA);
  assign timeout_hit  = (to_cnt == TO_LAST);
  assign timeout_fire = waiting && !bus_ack && timeout_hit;
  assign rsp_error            = err_q;
  assign status_timeout_count = to_count_q;

  // Watchdog: counts idle cycles while waiting on the responder; any
  // accepted ack or any other state restarts it from zero.
  always_ff @(posedge clock_signal or posedge reset_signal_active_high) begin
    if (reset_signal_active_high) begin
      to_cnt     <= '0;
      err_q      <= 1'b0;
      to_count_q <= 8'h00;
    end else begin
      if (waiting && !bus_ack && !timeout_hit) to_cnt <= to_cnt + 1'b1;
      else                                     to_cnt <= '0;

      if (state_q == IDLE && cmd_valid) err_q <= 1'b0;
      else if (timeout_fire)            err_q <= 1'b1;

      if (timeout_fire && to_count_q != 8'hFF) to_count_q <= to_count_q + 8'h01;
    end
  end
`else
  assign timeout_hit          = 1'b0;
  assign rsp_error            = 1'b0;
  assign status_timeout_count = 8'h00;
`endif

endmodule
